patch_window: RTL and testbench

PATCH_WINDOW -- requirements
Module: patch_window

---
 rtl/patch_window_pkg.sv | 10 +
 rtl/patch_window_if.sv | 26 ++
 rtl/line_delay.sv | 37 +++
 rtl/patch_window.sv | 114 +++++++++++
 tb/tb_patch_window.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/patch_window_pkg.sv
// Shared constants for the 3x3 patch extractor and the downstream convolution.
// Both blocks import this so kernel size and patch width stay in lockstep.
package patch_window_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned KSIZE      = 3;
    localparam int unsigned NTAPS      = KSIZE * KSIZE;
    localparam int unsigned PATCH_W    = NTAPS * DEF_DATA_W;

endpackage

// File: rtl/patch_window_if.sv
// Pixel stream in / patch stream out bundle for patch_window.
// master drives pixels, slave is the window generator.
interface patch_window_if #(
    parameter int unsigned DATA_W = patch_window_pkg::DEF_DATA_W
);

    localparam int unsigned PW = patch_window_pkg::NTAPS * DATA_W;

    logic              FRAME_START;
    logic [DATA_W-1:0] PIX_IN;
    logic              PIX_VALID;
    logic [PW-1:0]     PATCH;
    logic              PATCH_VALID;
    logic              FRAME_DONE;

    modport master (
        output FRAME_START, PIX_IN, PIX_VALID,
        input  PATCH, PATCH_VALID, FRAME_DONE
    );

    modport slave (
        input  FRAME_START, PIX_IN, PIX_VALID,
        output PATCH, PATCH_VALID, FRAME_DONE
    );

endinterface

// File: rtl/line_delay.sv
// Circular buffer delaying accepted samples by exactly DEPTH accepts.
// Storage is unreset so it maps onto RAM; only the pointer is reset.
module line_delay #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr_q;

    // Slot at ptr holds the sample from DEPTH accepts ago; it is read out and
    // overwritten with the new sample on the same edge.
    assign dout = mem[ptr_q];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/patch_window.sv
// Raster-scan 3x3 window generator: two line delays plus a shifting window,
// emitting one PATCH per accepted pixel whose window lies fully inside the image.
module patch_window
    import patch_window_pkg::*;
#(
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic           CLK,
    input  logic           rst_n,
    patch_window_if.slave  pw
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    logic [CW-1:0]     col_q, col_d, cur_col;
    logic [RW-1:0]     row_q, row_d, cur_row;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              last_col, last_row;
    logic [DATA_W-1:0] win_q [KSIZE][KSIZE];
    logic [DATA_W-1:0] win_d [KSIZE][KSIZE];
    logic [DATA_W-1:0] line1_out, line2_out;

    line_delay #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_W)
    ) u_line1 (
        .clk   (CLK),
        .rst_n (rst_n),
        .en    (pw.PIX_VALID),
        .din   (pw.PIX_IN),
        .dout  (line1_out)
    );

    line_delay #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_W)
    ) u_line2 (
        .clk   (CLK),
        .rst_n (rst_n),
        .en    (pw.PIX_VALID),
        .din   (line1_out),
        .dout  (line2_out)
    );

    // FRAME_START overrides the counters, so a pixel arriving with it is (0,0).
    always_comb begin
        cur_col  = pw.FRAME_START ? '0 : col_q;
        cur_row  = pw.FRAME_START ? '0 : row_q;
        last_col = (cur_col == CW'(IMG_W - 1));
        last_row = (cur_row == RW'(IMG_H - 1));
        col_d    = cur_col;
        row_d    = cur_row;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        if (pw.PIX_VALID) begin
            valid_d = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            done_d  = last_col && last_row;
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (pw.PIX_VALID) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            win_d[0][KSIZE-1] = line2_out;
            win_d[1][KSIZE-1] = line1_out;
            win_d[2][KSIZE-1] = pw.PIX_IN;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            win_q   <= '{default: '0};
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            win_q   <= win_d;
        end
    end

    // Row-major pack, top-left in the most significant slice.
    always_comb begin
        pw.PATCH = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                pw.PATCH[(NTAPS - 1 - (r * KSIZE + c)) * DATA_W +: DATA_W] = win_q[r][c];
            end
        end
    end

    assign pw.PATCH_VALID = valid_q;
    assign pw.FRAME_DONE  = done_q;

endmodule

// File: tb/tb_patch_window.sv
// Directed bench for patch_window on a 4x4 image with 16-bit pixels.
module tb_patch_window;
    import patch_window_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 16;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    patch_window_if #(.DATA_W(DW)) pw ();

    patch_window #(
        .IMG_W  (W),
        .IMG_H  (H),
        .DATA_W (DW)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .pw    (pw)
    );

    // Ramp image: the window whose top-left pixel has value v.
    function automatic logic [9*DW-1:0] exp_patch(input int v);
        logic [9*DW-1:0] p;
        p = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[(8 - (r * 3 + c)) * DW +: DW] = DW'(v + r * W + c);
        return p;
    endfunction

    function automatic logic pos_valid(input int pos);
        return ((pos % W) >= 2) && (((pos / W) % H) >= 2);
    endfunction

    task automatic step(input logic v, input logic fs, input int p);
        pw.PIX_VALID   = v;
        pw.FRAME_START = fs;
        pw.PIX_IN      = DW'(p);
        @(posedge CLK);
        #1;
        pw.PIX_VALID   = 1'b0;
        pw.FRAME_START = 1'b0;
    endtask

    task automatic test_reset();
        pw.PIX_VALID = 1'b0;
        pw.FRAME_START = 1'b0;
        pw.PIX_IN = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (pw.PATCH !== '0) begin
            errors++; $display("FAIL reset_patch got=%h exp=0", pw.PATCH);
        end
        checks++;
        if (pw.PATCH_VALID !== 1'b0 || pw.FRAME_DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b%b exp=00", pw.PATCH_VALID, pw.FRAME_DONE);
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 0);
    endtask

    task automatic test_ramp();
        int np = 0;
        logic [9*DW-1:0] first_exp, last_exp;
        first_exp = {16'd0, 16'd1, 16'd2, 16'd4, 16'd5, 16'd6, 16'd8, 16'd9, 16'd10};
        last_exp  = {16'd5, 16'd6, 16'd7, 16'd9, 16'd10, 16'd11, 16'd13, 16'd14, 16'd15};
        step(1'b0, 1'b1, 0);
        checks++;
        if (pw.PATCH_VALID !== 1'b0) begin
            errors++; $display("FAIL ramp_fs_valid got=%b exp=0", pw.PATCH_VALID);
        end
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, k);
            checks++;
            if (pw.PATCH_VALID !== pos_valid(k)) begin
                errors++;
                $display("FAIL ramp_valid k=%0d got=%b exp=%b", k, pw.PATCH_VALID, pos_valid(k));
            end
            if (pw.PATCH_VALID) np++;
            if (pos_valid(k)) begin
                checks++;
                if (pw.PATCH !== exp_patch(k - 10)) begin
                    errors++;
                    $display("FAIL ramp_patch k=%0d got=%h exp=%h", k, pw.PATCH, exp_patch(k - 10));
                end
            end
            if (k == 10 || k == 15) begin
                checks++;
                if (pw.PATCH !== ((k == 10) ? first_exp : last_exp)) begin
                    errors++;
                    $display("FAIL ramp_literal k=%0d got=%h", k, pw.PATCH);
                end
            end
            checks++;
            if (pw.FRAME_DONE !== (k == 15)) begin
                errors++; $display("FAIL ramp_done k=%0d got=%b exp=%b", k, pw.FRAME_DONE, k == 15);
            end
        end
        step(1'b0, 1'b0, 0);
        checks++;
        if (pw.FRAME_DONE !== 1'b0 || pw.PATCH_VALID !== 1'b0) begin
            errors++;
            $display("FAIL ramp_after got=%b%b exp=00", pw.FRAME_DONE, pw.PATCH_VALID);
        end
        checks++;
        if (np != 4) begin
            errors++; $display("FAIL ramp_count got=%0d exp=4", np);
        end
    endtask

    task automatic test_gaps();
        int np = 0;
        logic prev = 1'b0;
        step(1'b0, 1'b1, 0);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, k);
            checks++;
            if (pw.PATCH_VALID !== pos_valid(k)) begin
                errors++;
                $display("FAIL gap_valid k=%0d got=%b exp=%b", k, pw.PATCH_VALID, pos_valid(k));
            end
            if (pw.PATCH_VALID && prev) begin
                errors++; $display("FAIL gap_double k=%0d got=1 exp=0", k);
            end
            if (pw.PATCH_VALID) np++;
            if (pos_valid(k)) begin
                checks++;
                if (pw.PATCH !== exp_patch(k - 10)) begin
                    errors++;
                    $display("FAIL gap_patch k=%0d got=%h exp=%h", k, pw.PATCH, exp_patch(k - 10));
                end
            end
            prev = pw.PATCH_VALID;
            step(1'b0, 1'b0, 16'hdead);
            checks++;
            if (pw.PATCH_VALID !== 1'b0) begin
                errors++; $display("FAIL gap_idle_valid k=%0d got=%b exp=0", k, pw.PATCH_VALID);
            end
            if (pos_valid(k)) begin
                checks++;
                if (pw.PATCH !== exp_patch(k - 10)) begin
                    errors++;
                    $display("FAIL gap_hold k=%0d got=%h exp=%h", k, pw.PATCH, exp_patch(k - 10));
                end
            end
            prev = pw.PATCH_VALID;
        end
        checks++;
        if (np != 4) begin
            errors++; $display("FAIL gap_count got=%0d exp=4", np);
        end
    endtask

    task automatic test_reset_midframe();
        int np = 0;
        step(1'b0, 1'b1, 0);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, k);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pw.PATCH !== '0 || pw.PATCH_VALID !== 1'b0 || pw.FRAME_DONE !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got=%h/%b%b exp=0/00", pw.PATCH, pw.PATCH_VALID,
                     pw.FRAME_DONE);
        end
        @(posedge CLK);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b1, 0);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, 100 + k);
            checks++;
            if (pw.PATCH_VALID !== pos_valid(k)) begin
                errors++;
                $display("FAIL rst_valid k=%0d got=%b exp=%b", k, pw.PATCH_VALID, pos_valid(k));
            end
            if (pos_valid(k)) begin
                np++;
                checks++;
                if (pw.PATCH !== exp_patch(100 + k - 10)) begin
                    errors++;
                    $display("FAIL rst_patch k=%0d got=%h exp=%h", k, pw.PATCH,
                             exp_patch(100 + k - 10));
                end
            end
            if (k == 10) begin
                checks++;
                if (pw.PATCH !== {16'd100, 16'd101, 16'd102, 16'd104, 16'd105, 16'd106,
                                  16'd108, 16'd109, 16'd110}) begin
                    errors++; $display("FAIL rst_first got=%h", pw.PATCH);
                end
            end
        end
        checks++;
        if (np != 4) begin
            errors++; $display("FAIL rst_count got=%0d exp=4", np);
        end
    endtask

    task automatic test_fs_midframe();
        int np = 0;
        step(1'b0, 1'b1, 0);
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, k);
        step(1'b1, 1'b1, 7);
        checks++;
        if (pw.PATCH_VALID !== 1'b0) begin
            errors++; $display("FAIL fs_restart_valid got=%b exp=0", pw.PATCH_VALID);
        end
        for (int k = 8; k < 23; k++) begin
            step(1'b1, 1'b0, k);
            checks++;
            if (pw.PATCH_VALID !== pos_valid(k - 7)) begin
                errors++;
                $display("FAIL fs_valid k=%0d got=%b exp=%b", k, pw.PATCH_VALID, pos_valid(k - 7));
            end
            if (pos_valid(k - 7)) begin
                np++;
                checks++;
                if (pw.PATCH !== exp_patch(k - 10)) begin
                    errors++;
                    $display("FAIL fs_patch k=%0d got=%h exp=%h", k, pw.PATCH, exp_patch(k - 10));
                end
            end
            checks++;
            if (pw.FRAME_DONE !== (k == 22)) begin
                errors++; $display("FAIL fs_done k=%0d got=%b exp=%b", k, pw.FRAME_DONE, k == 22);
            end
        end
        checks++;
        if (np != 4) begin
            errors++; $display("FAIL fs_count got=%0d exp=4", np);
        end
    endtask

    task automatic test_back_to_back();
        int np = 0;
        int nd = 0;
        int d0 = -1;
        int d1 = -1;
        step(1'b0, 1'b1, 0);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, i);
            checks++;
            if (pw.PATCH_VALID !== pos_valid(i % 16)) begin
                errors++;
                $display("FAIL b2b_valid i=%0d got=%b exp=%b", i, pw.PATCH_VALID,
                         pos_valid(i % 16));
            end
            if (pw.PATCH_VALID) begin
                np++;
                checks++;
                if (pw.PATCH !== exp_patch(i - 10)) begin
                    errors++;
                    $display("FAIL b2b_patch i=%0d got=%h exp=%h", i, pw.PATCH, exp_patch(i - 10));
                end
            end
            if (pw.FRAME_DONE) begin
                if (nd == 0) d0 = i;
                else d1 = i;
                nd++;
            end
        end
        checks++;
        if (np != 8) begin
            errors++; $display("FAIL b2b_count got=%0d exp=8", np);
        end
        checks++;
        if (nd != 2 || d1 - d0 != 16 || d0 != 15) begin
            errors++; $display("FAIL b2b_done got=%0d pulses at %0d,%0d exp=2 at 15,31", nd, d0, d1);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gaps();
        test_reset_midframe();
        test_fs_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
